// File: rtl/indec_with_delim_20_8_pkg.sv
// Shared constants and state encodings for the decimal-input routine
// and its serial byte receiver.
package indec_with_delim_20_8_pkg;

  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_9 = 8'h39;

  localparam int CLKS_PER_BIT_DEFAULT = 868;
  localparam int MAXVAL_DEFAULT       = 1048575;

  typedef enum logic [1:0] {
    READY  = 2'd0,
    SKIP   = 2'd1,
    DIGITS = 2'd2,
    MAC    = 2'd3
  } parse_state_t;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

endpackage

// File: rtl/indec_with_delim_20_8_if.sv
// Call/return handshake of the decimal-input routine: the caller pulses
// start and collects result/termbyte/overflow once result_ready is high.
interface indec_with_delim_20_8_if;

  logic        start;
  logic [19:0] result;
  logic [7:0]  termbyte;
  logic        overflow;
  logic        result_ready;

  modport master (
    output start,
    input  result,
    input  termbyte,
    input  overflow,
    input  result_ready
  );

  modport slave (
    input  start,
    output result,
    output termbyte,
    output overflow,
    output result_ready
  );

endinterface

// File: rtl/indec_with_delim_20_8_inbyte.sv
// 8N1 UART byte receiver, the receive-side twin of outbyte115200_1_1_8.
// Runs continuously; byte_valid pulses one cycle per well-framed byte.
module inbyte115200_1_8
  import indec_with_delim_20_8_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inchan,
  output logic [7:0] rx_byte,
  output logic       byte_valid
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  logic          sync_q1, rx_s;
  rx_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    rx_byte_n;
  logic          valid_n;

  // Line idles high, so the synchronizer resets to 1 to avoid a fake start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync_q1 <= inchan;
      rx_s    <= sync_q1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      rx_byte    <= rx_byte_n;
      byte_valid <= valid_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    rx_byte_n = rx_byte;
    valid_n   = 1'b0;

    case (state)
      RX_IDLE: begin
        if (!rx_s) begin
          cnt_n   = '0;
          state_n = RX_START;
        end
      end

      // Re-check the line half a bit later; a short low pulse is a glitch.
      RX_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_cnt_n = '0;
          state_n   = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      RX_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift[7:1]};
          if (bit_cnt == 3'd7) begin
            state_n = RX_STOP;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      RX_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            rx_byte_n = shift;
            valid_n   = 1'b1;
            state_n   = RX_IDLE;
          end else begin
            state_n = RX_WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      // Framing error: hold off until the line goes idle again.
      RX_WAIT_HIGH: begin
        if (rx_s) begin
          state_n = RX_IDLE;
        end
      end

      default: begin
        state_n = RX_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/indec_with_delim_20_8.sv
// Parses one unsigned decimal number from the UART line into a saturating
// 20-bit result and reports the non-digit byte that terminated it.
module indec_with_delim_20_8
  import indec_with_delim_20_8_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int MAXVAL       = MAXVAL_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inchan,
  indec_with_delim_20_8_if.slave bus
);

  localparam logic [19:0] MAXVAL_20 = 20'(MAXVAL);
  localparam logic [24:0] MAXVAL_25 = 25'(MAXVAL);

  logic [7:0]   rx_byte;
  logic         byte_valid;

  parse_state_t state, state_n;
  logic [19:0]  acc, acc_n;
  logic [3:0]   digit, digit_n;
  logic [19:0]  result, result_n;
  logic [7:0]   termbyte, termbyte_n;
  logic         overflow, overflow_n;
  logic [24:0]  acc_wide;
  logic [24:0]  tmp;

  inbyte115200_1_8 #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .inchan     (inchan),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= READY;
      acc      <= '0;
      digit    <= '0;
      result   <= '0;
      termbyte <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      digit    <= digit_n;
      result   <= result_n;
      termbyte <= termbyte_n;
      overflow <= overflow_n;
    end
  end

  // acc*10 + digit without a multiplier; 25 bits cover MAXVAL*10 + 9.
  assign acc_wide = {5'd0, acc};
  assign tmp      = (acc_wide << 3) + (acc_wide << 1) + {21'd0, digit};

  always_comb begin
    state_n    = state;
    acc_n      = acc;
    digit_n    = digit;
    result_n   = result;
    termbyte_n = termbyte;
    overflow_n = overflow;

    // A start pulse always wins, even over a byte completing this cycle.
    if (bus.start) begin
      state_n    = SKIP;
      acc_n      = '0;
      overflow_n = 1'b0;
    end else begin
      case (state)
        READY: begin
        end

        SKIP: begin
          if (byte_valid && is_digit(rx_byte)) begin
            acc_n   = {16'd0, rx_byte[3:0]};
            state_n = DIGITS;
          end
        end

        DIGITS: begin
          if (byte_valid) begin
            if (is_digit(rx_byte)) begin
              digit_n = rx_byte[3:0];
              state_n = MAC;
            end else begin
              result_n   = acc;
              termbyte_n = rx_byte;
              state_n    = READY;
            end
          end
        end

        MAC: begin
          if (tmp > MAXVAL_25) begin
            acc_n      = MAXVAL_20;
            overflow_n = 1'b1;
          end else begin
            acc_n = tmp[19:0];
          end
          state_n = DIGITS;
        end

        default: begin
          state_n = READY;
        end
      endcase
    end
  end

  assign bus.result       = result;
  assign bus.termbyte     = termbyte;
  assign bus.overflow     = overflow;
  assign bus.result_ready = (state == READY) && !bus.start;

endmodule

// File: tb/tb_indec_with_delim_20_8.sv
// Directed bench for indec_with_delim_20_8 using a shortened UART bit time
// so whole serial streams fit in a brief simulation.
module tb_indec_with_delim_20_8;

  localparam int CLKS   = 32;
  localparam int MAXVAL = 1048575;

  logic clk;
  logic rst_n;
  logic inchan;

  int checks_total  = 0;
  int checks_passed = 0;

  indec_with_delim_20_8_if bus ();

  indec_with_delim_20_8 #(
    .CLKS_PER_BIT (CLKS),
    .MAXVAL       (MAXVAL)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .inchan (inchan),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    inchan = 1'b0;
    repeat (CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      inchan = b[i];
      repeat (CLKS) @(negedge clk);
    end
    inchan = stop_bit;
    repeat (CLKS) @(negedge clk);
    inchan = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_string(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], 1'b1);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    #1;
    checks_total++;
    if (bus.result_ready !== 1'b0)
      $display("[TB] FAIL ready_during_start: got %b want 0", bus.result_ready);
    else
      checks_passed++;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (bus.result_ready !== 1'b1 && n < 4 * CLKS) begin
      @(negedge clk);
      n++;
    end
    checks_total++;
    if (bus.result_ready !== 1'b1)
      $display("[TB] FAIL %s_ready: got %b want 1 (timeout)", name, bus.result_ready);
    else
      checks_passed++;
  endtask

  task automatic check_outputs(input string name, input logic [19:0] exp_res,
                               input logic [7:0] exp_term, input logic exp_ovf);
    checks_total++;
    if (bus.result !== exp_res)
      $display("[TB] FAIL %s_result: got %0d want %0d", name, bus.result, exp_res);
    else
      checks_passed++;
    checks_total++;
    if (bus.termbyte !== exp_term)
      $display("[TB] FAIL %s_termbyte: got %h want %h", name, bus.termbyte, exp_term);
    else
      checks_passed++;
    checks_total++;
    if (bus.overflow !== exp_ovf)
      $display("[TB] FAIL %s_overflow: got %b want %b", name, bus.overflow, exp_ovf);
    else
      checks_passed++;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    inchan    = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs("reset", 20'd0, 8'h00, 1'b0);
    checks_total++;
    if (bus.result_ready !== 1'b1)
      $display("[TB] FAIL reset_ready: got %b want 1", bus.result_ready);
    else
      checks_passed++;
  endtask

  task automatic test_basic();
    pulse_start();
    send_string("123");
    checks_total++;
    if (bus.result_ready !== 1'b0)
      $display("[TB] FAIL basic_busy: got %b want 0", bus.result_ready);
    else
      checks_passed++;
    checks_total++;
    if (bus.result !== 20'd0)
      $display("[TB] FAIL basic_hold: got %0d want 0", bus.result);
    else
      checks_passed++;
    send_byte(8'h0D, 1'b1);
    wait_ready("basic");
    check_outputs("basic", 20'd123, 8'h0D, 1'b0);
  endtask

  task automatic test_delimiters();
    pulse_start();
    send_string(" ,0042,");
    wait_ready("delim");
    check_outputs("delim", 20'd42, 8'h2C, 1'b0);
  endtask

  task automatic test_overflow();
    pulse_start();
    send_string("1048576\n");
    wait_ready("ovf");
    check_outputs("ovf", 20'd1048575, 8'h0A, 1'b1);
    pulse_start();
    checks_total++;
    if (bus.overflow !== 1'b0)
      $display("[TB] FAIL ovf_clear_on_start: got %b want 0", bus.overflow);
    else
      checks_passed++;
    send_string("7\n");
    wait_ready("after_ovf");
    check_outputs("after_ovf", 20'd7, 8'h0A, 1'b0);
  endtask

  task automatic test_restart();
    pulse_start();
    send_string("9");
    pulse_start();
    send_string("85;");
    wait_ready("restart");
    check_outputs("restart", 20'd85, 8'h3B, 1'b0);
  endtask

  task automatic test_glitch_framing();
    pulse_start();
    @(negedge clk);
    inchan = 1'b0;
    repeat (10) @(negedge clk);
    inchan = 1'b1;
    repeat (2 * CLKS) @(negedge clk);
    send_byte(8'h35, 1'b0);
    repeat (CLKS) @(negedge clk);
    checks_total++;
    if (bus.result_ready !== 1'b0)
      $display("[TB] FAIL glitch_busy: got %b want 0", bus.result_ready);
    else
      checks_passed++;
    send_string("6\n");
    wait_ready("glitch");
    check_outputs("glitch", 20'd6, 8'h0A, 1'b0);
  endtask

  task automatic test_async_reset();
    pulse_start();
    send_string("1048576");
    checks_total++;
    if (bus.overflow !== 1'b1)
      $display("[TB] FAIL midparse_overflow: got %b want 1", bus.overflow);
    else
      checks_passed++;
    fork
      send_byte(8'h33, 1'b1);
      begin
        repeat (4 * CLKS) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 20'd0, 8'h00, 1'b0);
        checks_total++;
        if (bus.result_ready !== 1'b1)
          $display("[TB] FAIL async_rst_ready: got %b want 1", bus.result_ready);
        else
          checks_passed++;
        repeat (3 * CLKS) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    send_byte(8'h0A, 1'b1);
    repeat (2 * CLKS) @(negedge clk);
    check_outputs("post_rst", 20'd0, 8'h00, 1'b0);
    checks_total++;
    if (bus.result_ready !== 1'b1)
      $display("[TB] FAIL post_rst_ready: got %b want 1", bus.result_ready);
    else
      checks_passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delimiters();
    test_overflow();
    test_restart();
    test_glitch_framing();
    test_async_reset();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
